// File: rtl/msg_request_queue_pkg.sv
// Shared session definitions for the message-request queue: message type codes,
// default field widths, queue FSM state encoding and FIFO entry width.
package msg_request_queue_pkg;

    localparam int TYPE_W           = 4;
    localparam int VALUE_DATA_WIDTH = 32;
    localparam int VALUE_SIZE       = 8;
    localparam int ENTRY_W          = TYPE_W + VALUE_DATA_WIDTH + VALUE_SIZE;

    // Type code 0 is reserved as "no order".
    localparam logic [3:0] MSG_NONE       = 4'h0;
    localparam logic [3:0] MSG_LOGON      = 4'h1;
    localparam logic [3:0] MSG_LOGOUT     = 4'h2;
    localparam logic [3:0] MSG_HEARTBEAT  = 4'h3;
    localparam logic [3:0] MSG_RESEND_REQ = 4'h4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mrq_state_e;

    function automatic int entry_width(input int value_w, input int size_w);
        return TYPE_W + value_w + size_w;
    endfunction

endpackage

// File: rtl/msg_request_queue_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full/empty flags are registered
// from the next-state pointers so they line up with the pointer registers.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [WIDTH-1:0]    mem_r [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_r;
    logic [DEPTH_LOG2:0] rd_ptr_r;
    logic [DEPTH_LOG2:0] wr_ptr_nxt_s;
    logic [DEPTH_LOG2:0] rd_ptr_nxt_s;
    logic                full_r;
    logic                empty_r;
    logic                do_push_s;
    logic                do_pop_s;

    // A push while full is only accepted when a pop frees the head slot in the same cycle.
    assign do_push_s = push && (!full_r || pop);
    assign do_pop_s  = pop && !empty_r;

    // Next-state pointer arithmetic.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (do_push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (do_pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Pointer and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            empty_r  <= (wr_ptr_nxt_s == rd_ptr_nxt_s);
            full_r   <= (wr_ptr_nxt_s[DEPTH_LOG2] != rd_ptr_nxt_s[DEPTH_LOG2]) &&
                        (wr_ptr_nxt_s[DEPTH_LOG2-1:0] == rd_ptr_nxt_s[DEPTH_LOG2-1:0]);
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/msg_request_queue.sv
// Queues message-creation orders from session_manager and hands them to
// create_message one at a time. Optional watchdog: define MSG_QUEUE_WATCHDOG_EN.
module msg_request_queue
    import msg_request_queue_pkg::*;
#(
    parameter int VALUE_WIDTH = VALUE_DATA_WIDTH,
    parameter int SIZE        = VALUE_SIZE,
    parameter int DEPTH_LOG2  = 3,
    parameter int DROP_CNT_W  = 8
`ifdef MSG_QUEUE_WATCHDOG_EN
    ,
    parameter int WD_CYCLES   = 1024
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   initiate_msg_i,
    input  logic [3:0]             create_message_i,
    input  logic [VALUE_WIDTH-1:0] targetCompId_i,
    input  logic [SIZE-1:0]        s_v_targetCompId_i,
    input  logic                   cm_busy_i,
    input  logic                   cm_done_i,
    output logic                   initiate_msg_o,
    output logic [3:0]             create_message_o,
    output logic [VALUE_WIDTH-1:0] targetCompId_o,
    output logic [SIZE-1:0]        s_v_targetCompId_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic                   overflow_o,
    output logic [DROP_CNT_W-1:0]  drop_cnt_o
`ifdef MSG_QUEUE_WATCHDOG_EN
    ,
    output logic                   wd_err_o
`endif
);

    localparam int Q_ENTRY_W = entry_width(VALUE_WIDTH, SIZE);
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};
    localparam logic [DROP_CNT_W-1:0] DROP_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

    mrq_state_e           state_r;
    mrq_state_e           state_nxt_s;
    logic                 push_req_s;
    logic                 pop_s;
    logic                 drop_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [Q_ENTRY_W-1:0] fifo_wdata_s;
    logic [Q_ENTRY_W-1:0] fifo_rdata_s;
    logic                 wd_fire_s;

    assign push_req_s   = initiate_msg_i && (create_message_i != MSG_NONE);
    assign drop_s       = push_req_s && fifo_full_s && !pop_s;
    assign fifo_wdata_s = {create_message_i, targetCompId_i, s_v_targetCompId_i};

    sync_fifo #(
        .WIDTH      (Q_ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req_s),
        .pop   (pop_s),
        .wdata (fifo_wdata_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

`ifdef MSG_QUEUE_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    logic [WD_W-1:0] wd_cnt_r;

    // WAIT-state age counter; zero on the first WAIT cycle after each issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_r <= '0;
            wd_err_o <= 1'b0;
        end else begin
            wd_err_o <= wd_fire_s;
            if (state_r == ST_WAIT && state_nxt_s == ST_WAIT) begin
                wd_cnt_r <= wd_cnt_r + WD_ONE;
            end else begin
                wd_cnt_r <= '0;
            end
        end
    end
`endif

    // Next-state and pop decision; a timed-out order is simply abandoned.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        wd_fire_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && !cm_busy_i) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cm_done_i) begin
                    state_nxt_s = ST_IDLE;
`ifdef MSG_QUEUE_WATCHDOG_EN
                end else if (wd_cnt_r == WD_LAST) begin
                    state_nxt_s = ST_IDLE;
                    wd_fire_s   = 1'b1;
`endif
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered strobe and payload toward create_message.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r            <= ST_IDLE;
            initiate_msg_o     <= 1'b0;
            create_message_o   <= 4'h0;
            targetCompId_o     <= '0;
            s_v_targetCompId_o <= '0;
        end else begin
            state_r        <= state_nxt_s;
            initiate_msg_o <= pop_s;
            if (pop_s) begin
                {create_message_o, targetCompId_o, s_v_targetCompId_o} <= fifo_rdata_s;
            end
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop_s) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != DROP_MAX) begin
                drop_cnt_o <= drop_cnt_o + DROP_ONE;
            end
        end
    end

    assign empty_o = fifo_empty_s;
    assign full_o  = fifo_full_s;

endmodule

// File: tb/tb_msg_request_queue.sv
// Directed self-checking bench for msg_request_queue (default build, DEPTH 8).
module tb_msg_request_queue;
    import msg_request_queue_pkg::*;

    localparam int VW = VALUE_DATA_WIDTH;
    localparam int SW = VALUE_SIZE;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          initiate_msg_i = 1'b0;
    logic [3:0]    create_message_i = 4'h0;
    logic [VW-1:0] targetCompId_i = '0;
    logic [SW-1:0] s_v_targetCompId_i = '0;
    logic          cm_busy_i = 1'b0;
    logic          cm_done_i = 1'b0;
    logic          initiate_msg_o;
    logic [3:0]    create_message_o;
    logic [VW-1:0] targetCompId_o;
    logic [SW-1:0] s_v_targetCompId_o;
    logic          empty_o;
    logic          full_o;
    logic          overflow_o;
    logic [7:0]    drop_cnt_o;
`ifdef MSG_QUEUE_WATCHDOG_EN
    logic          wd_err_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [3:0]    st_type [$];
    logic [VW-1:0] st_val  [$];
    int            st_cyc  [$];
    int            done_cyc[$];

    logic [3:0] codes [4];

    msg_request_queue dut (
        .clk                (clk),
        .rst                (rst),
        .initiate_msg_i     (initiate_msg_i),
        .create_message_i   (create_message_i),
        .targetCompId_i     (targetCompId_i),
        .s_v_targetCompId_i (s_v_targetCompId_i),
        .cm_busy_i          (cm_busy_i),
        .cm_done_i          (cm_done_i),
        .initiate_msg_o     (initiate_msg_o),
        .create_message_o   (create_message_o),
        .targetCompId_o     (targetCompId_o),
        .s_v_targetCompId_o (s_v_targetCompId_o),
        .empty_o            (empty_o),
        .full_o             (full_o),
        .overflow_o         (overflow_o),
        .drop_cnt_o         (drop_cnt_o)
`ifdef MSG_QUEUE_WATCHDOG_EN
        ,
        .wd_err_o           (wd_err_o)
`endif
    );

    always #5 clk = ~clk;

    // Record every issue strobe and done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (initiate_msg_o === 1'b1) begin
            st_type.push_back(create_message_o);
            st_val.push_back(targetCompId_o);
            st_cyc.push_back(cyc);
        end
        if (cm_done_i === 1'b1) begin
            done_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_log();
        st_type.delete();
        st_val.delete();
        st_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic wait_strobes(input int n, input string tag);
        int budget = 40;
        while (st_type.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        chk(tag, 64'(st_type.size()), 64'(n));
    endtask

    task automatic done_pulse();
        cm_done_i = 1'b1;
        tick();
        cm_done_i = 1'b0;
    endtask

    task automatic drive_push(input logic [3:0] t, input logic [VW-1:0] v, input logic [SW-1:0] s);
        initiate_msg_i     = 1'b1;
        create_message_i   = t;
        targetCompId_i     = v;
        s_v_targetCompId_i = s;
        tick();
        initiate_msg_i     = 1'b0;
        create_message_i   = 4'h0;
    endtask

    initial begin
        codes = '{MSG_LOGON, MSG_LOGOUT, MSG_HEARTBEAT, MSG_RESEND_REQ};

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_init",  64'(initiate_msg_o), 64'd0);
        chk("rst_type",  64'(create_message_o), 64'd0);
        chk("rst_val",   64'(targetCompId_o), 64'd0);
        chk("rst_size",  64'(s_v_targetCompId_o), 64'd0);
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_full",  64'(full_o), 64'd0);
        chk("rst_ovf",   64'(overflow_o), 64'd0);
        chk("rst_drop",  64'(drop_cnt_o), 64'd0);

        // Type 0 strobe is ignored and not counted as a drop
        drive_push(4'h0, 32'h55, 8'd1);
        chk("t0_empty", 64'(empty_o), 64'd1);
        tick();
        chk("t0_init", 64'(initiate_msg_o), 64'd0);
        chk("t0_drop", 64'(drop_cnt_o), 64'd0);

        // Single order: strobe exactly two cycles after the push
        drive_push(MSG_LOGON, 32'hAB, 8'd3);
        chk("single_n1_init",  64'(initiate_msg_o), 64'd0);
        chk("single_n1_empty", 64'(empty_o), 64'd0);
        tick();
        chk("single_n2_init",  64'(initiate_msg_o), 64'd1);
        chk("single_type",     64'(create_message_o), 64'(MSG_LOGON));
        chk("single_val",      64'(targetCompId_o), 64'hAB);
        chk("single_size",     64'(s_v_targetCompId_o), 64'd3);
        tick();
        chk("single_n3_init",  64'(initiate_msg_o), 64'd0);
        chk("single_hold_val", 64'(targetCompId_o), 64'hAB);
        done_pulse();
        tick();
        chk("single_done_empty", 64'(empty_o), 64'd1);
        chk("single_no_restrobe", 64'(initiate_msg_o), 64'd0);

        // Burst of three back-to-back pushes
        clear_log();
        initiate_msg_i = 1'b1;
        create_message_i = MSG_HEARTBEAT; targetCompId_i = 32'h11; tick();
        create_message_i = MSG_RESEND_REQ; targetCompId_i = 32'h22; tick();
        create_message_i = MSG_LOGOUT;     targetCompId_i = 32'h33; tick();
        initiate_msg_i = 1'b0;
        create_message_i = 4'h0;
        for (int k = 0; k < 3; k++) begin
            wait_strobes(k + 1, "burst_strobe_seen");
            repeat (4) tick();
            done_pulse();
        end
        repeat (6) tick();
        chk("burst_count", 64'(st_type.size()), 64'd3);
        if (st_type.size() == 3 && done_cyc.size() == 3) begin
            chk("burst_t0", 64'(st_type[0]), 64'(MSG_HEARTBEAT));
            chk("burst_t1", 64'(st_type[1]), 64'(MSG_RESEND_REQ));
            chk("burst_t2", 64'(st_type[2]), 64'(MSG_LOGOUT));
            chk("burst_v2", 64'(st_val[2]), 64'h33);
            chk("burst_gap1", 64'(st_cyc[1] - done_cyc[0]), 64'd2);
            chk("burst_gap2", 64'(st_cyc[2] - done_cyc[1]), 64'd2);
        end else begin
            chk("burst_log_sizes", 64'(done_cyc.size()), 64'd3);
        end

        // Overflow with a stalled consumer
        clear_log();
        cm_busy_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_push(codes[i % 4], VW'(i), 8'd2);
            if (i == 7) begin
                chk("ovf_full_at8", 64'(full_o), 64'd1);
                chk("ovf_no_drop_at8", 64'(overflow_o), 64'd0);
            end
        end
        chk("ovf_full",  64'(full_o), 64'd1);
        chk("ovf_flag",  64'(overflow_o), 64'd1);
        chk("ovf_drops", 64'(drop_cnt_o), 64'd2);
        chk("ovf_no_issue_busy", 64'(st_type.size()), 64'd0);
        cm_busy_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wait_strobes(k + 1, "ovf_drain_seen");
            tick();
            done_pulse();
        end
        repeat (4) tick();
        chk("ovf_drain_count", 64'(st_type.size()), 64'd8);
        for (int k = 0; k < 8 && k < st_val.size(); k++) begin
            chk("ovf_drain_val", 64'(st_val[k]), 64'(k));
            chk("ovf_drain_type", 64'(st_type[k]), 64'(codes[k % 4]));
        end
        chk("ovf_drain_empty", 64'(empty_o), 64'd1);
        chk("ovf_sticky", 64'(overflow_o), 64'd1);

        // Full queue: push coincides with pop, nothing dropped
        cm_busy_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_push(MSG_HEARTBEAT, VW'(100 + i), 8'd4);
        end
        chk("pp_full_before", 64'(full_o), 64'd1);
        clear_log();
        cm_busy_i = 1'b0;
        drive_push(MSG_LOGON, VW'(200), 8'd5);
        chk("pp_full_after", 64'(full_o), 64'd1);
        chk("pp_drop_same",  64'(drop_cnt_o), 64'd2);
        for (int k = 0; k < 9; k++) begin
            wait_strobes(k + 1, "pp_drain_seen");
            tick();
            done_pulse();
        end
        repeat (4) tick();
        chk("pp_count", 64'(st_val.size()), 64'd9);
        if (st_val.size() == 9) begin
            chk("pp_first", 64'(st_val[0]), 64'd100);
            chk("pp_last",  64'(st_val[8]), 64'd200);
        end else begin
            chk("pp_log_size", 64'(st_val.size()), 64'd9);
        end

        // Reset while waiting with four orders queued
        clear_log();
        for (int i = 0; i < 5; i++) begin
            drive_push(MSG_LOGOUT, VW'(300 + i), 8'd6);
        end
        tick();
        chk("rw_one_issued", 64'(st_type.size()), 64'd1);
        chk("rw_not_empty",  64'(empty_o), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_init",  64'(initiate_msg_o), 64'd0);
        chk("rw_type",  64'(create_message_o), 64'd0);
        chk("rw_val",   64'(targetCompId_o), 64'd0);
        chk("rw_size",  64'(s_v_targetCompId_o), 64'd0);
        chk("rw_empty", 64'(empty_o), 64'd1);
        chk("rw_full",  64'(full_o), 64'd0);
        chk("rw_ovf",   64'(overflow_o), 64'd0);
        chk("rw_drop",  64'(drop_cnt_o), 64'd0);
        clear_log();
        repeat (10) tick();
        chk("rw_no_strobe", 64'(st_type.size()), 64'd0);
        drive_push(MSG_RESEND_REQ, VW'(400), 8'd7);
        wait_strobes(1, "rw_new_seen");
        if (st_val.size() > 0) begin
            chk("rw_new_val", 64'(st_val[0]), 64'd400);
        end else begin
            chk("rw_new_missing", 64'(st_val.size()), 64'd1);
        end
        done_pulse();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/msg_request_queue.md
Name: msg_request_queue

Overview:
- Sits between session_manager and create_message.
- Captures each message-creation order pulsed by session_manager (type + targetCompID + size) into a FIFO.
- Releases orders one at a time to create_message, holding the next order until create_message reports the current one finished.
- Prevents lost logon/logout/heartbeat/resendReq orders when session_manager issues back-to-back requests.

Parameters:
- VALUE_WIDTH, `VALUE_DATA_WIDTH, width of the targetCompID value field.
- SIZE, `VALUE_SIZE, width of the targetCompID size field.
- DEPTH_LOG2, 3, log2 of the FIFO depth (8 entries by default).
- DROP_CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- initiate_msg_i  in  1  one-cycle order strobe from session_manager.
- create_message_i  in  4  message type code (`logon/`logout/`heartbeat/`resendReq).
- targetCompId_i  in  VALUE_WIDTH  target CompID value.
- s_v_targetCompId_i  in  SIZE  target CompID size.
- cm_busy_i  in  1  create_message is building a message.
- cm_done_i  in  1  one-cycle pulse: create_message has finished the current message.
- initiate_msg_o  out  1  one-cycle order strobe to create_message.
- create_message_o  out  4  type of the issued order.
- targetCompId_o  out  VALUE_WIDTH  CompID value of the issued order.
- s_v_targetCompId_o  out  SIZE  CompID size of the issued order.
- empty_o  out  1  FIFO empty.
- full_o  out  1  FIFO full.
- overflow_o  out  1  sticky; set on the first dropped order.
- drop_cnt_o  out  DROP_CNT_W  count of dropped orders; saturates at all-ones.

Behaviour:
- Reset values:
  - All outputs 0, except empty_o=1.
  - FIFO pointers 0; FSM in IDLE.
  - rst mid-operation flushes all queued and in-flight orders with no strobe.
- Push:
  - initiate_msg_i=1 and create_message_i!=0 writes {type, value, size} at the write pointer.
  - initiate_msg_i with type 0 is ignored; it is not counted as a drop.
- Full:
  - A push with no pop in the same cycle is dropped.
  - A dropped push sets overflow_o and increments drop_cnt_o, saturating.
  - A simultaneous push and pop when full is accepted; the count stays at DEPTH.
- Empty:
  - A pop never occurs when empty.
  - Push into an empty FIFO is visible to the FSM the next cycle; there is no bypass.
- Pointers are DEPTH_LOG2+1 bits wide.
  - full = MSBs differ and lower bits equal.
  - empty = pointers equal.
  - Wrap-around is natural modulo 2^(DEPTH_LOG2+1).
- FSM states and transitions:
  - IDLE: if !empty and !cm_busy_i, pop the head, register it onto the *_o payload and set initiate_msg_o=1. Go to WAIT.
  - WAIT: initiate_msg_o=0; the payload outputs hold their value. On cm_done_i go to IDLE.
  - cm_done_i in IDLE is ignored.
- Latency: an order pushed in cycle N into an empty queue with an idle consumer gives initiate_msg_o=1 in cycle N+2.
- Back-to-back: the next order issues no earlier than 2 cycles after cm_done_i (one IDLE evaluation cycle, then the registered strobe).
- Ordering: strict FIFO. Exactly one initiate_msg_o pulse per accepted order.
- Simultaneous push and cm_done_i: both take effect in the same cycle.

Optional Feature:
- Macro MSG_QUEUE_WATCHDOG_EN.
- When defined:
  - Adds parameter WD_CYCLES (default 1024) and output wd_err_o (1 bit, reset 0).
  - A counter runs in WAIT.
  - If cm_done_i is not seen within WD_CYCLES cycles, the FSM returns to IDLE and pulses wd_err_o for one cycle. The stuck order is discarded.
  - The counter clears on entry to WAIT.
- When undefined:
  - No counter and no wd_err_o port.
  - WAIT persists indefinitely until cm_done_i.

Decomposition:
- Message type codes come from defines.vh: `logon, `logout, `heartbeat, `resendReq, plus the width macros.
- Put the FSM state encodings (IDLE=1'b0, WAIT=1'b1) and the entry-width localparam (4+VALUE_WIDTH+SIZE) in the shared session package alongside them.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty) instantiated here. The FSM, drop logic and watchdog stay in the top.

Test Plan:
- Single order: push `logon with value 0xAB and size 3, consumer idle → initiate_msg_o pulses at N+2 with type `logon, 0xAB, 3. Then cm_done_i → empty_o=1 and the FSM is in IDLE.
- Burst: push `heartbeat, `resendReq, `logout on 3 consecutive cycles; pulse cm_done_i 5 cycles after each issue → exactly 3 strobes, in push order, each at least 2 cycles after the previous done.
- Overflow: hold cm_busy_i=1, push 10 orders with DEPTH_LOG2=3 → full_o=1 after 8, overflow_o=1, drop_cnt_o=2. Release → the first 8 orders issue in order.
- Full with simultaneous push and pop: fill to 8 entries, then push on the same cycle a pop occurs → no drop, count stays 8, drop_cnt_o unchanged.
- Reset mid-WAIT with 4 queued orders → next cycle all outputs 0, empty_o=1, no strobe until a new push.
- Watchdog (MSG_QUEUE_WATCHDOG_EN, WD_CYCLES=16): issue an order and never send cm_done_i → wd_err_o pulses at cycle 16 of WAIT, and the next queued order issues 2 cycles later.
